// File: rtl/subs_layer_serial.sv
// Iterative 4-bit S-box substitution layer: LANES nibbles per clock, forward or inverse
// mode latched per block, valid/ready handshake on both sides.
module subs_layer_serial #(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLOCK_SIZE-1:0] in_data,
  input  logic                  in_inverse,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] out_data,
  output logic                  busy
);

  localparam int unsigned GROUPS = (LANES == 0) ? 1 : BLOCK_SIZE / (4 * LANES);
  localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (!(BLOCK_SIZE == 64 || BLOCK_SIZE == 128) || LANES == 0 ||
        (BLOCK_SIZE % (4 * LANES)) != 0) begin : g_bad_params
      $error("subs_layer_serial: illegal BLOCK_SIZE/LANES combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    sbox_fwd = 4'h0;
    case (x)
      4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;
      4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
      4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;
      4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
      4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;
      4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
      4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;
      4'hE: sbox_fwd = 4'h1;  4'hF: sbox_fwd = 4'h2;
      default: sbox_fwd = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    sbox_inv = 4'h0;
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;
      4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;
      4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;
      4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;
      4'hE: sbox_inv = 4'h9;  4'hF: sbox_inv = 4'hA;
      default: sbox_inv = 4'h0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [BLOCK_SIZE-1:0] work_q, work_d, sub_word;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;

  // Working word with the group selected by the counter substituted.
  always_comb begin
    sub_word = work_q;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (cnt_q == CNT_W'(g)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          sub_word[(g*LANES+l)*4 +: 4] = mode_q ? sbox_inv(work_q[(g*LANES+l)*4 +: 4])
                                                : sbox_fwd(work_q[(g*LANES+l)*4 +: 4]);
        end
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = in_inverse;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d = sub_word;
        if (cnt_q == CNT_W'(GROUPS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_subs_layer_serial.sv
// Self-checking bench for subs_layer_serial: vector table, handshake corner cases,
// random blocks against a nibble-table reference model, and a 128-bit lane sweep.
module tb_subs_layer_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_inverse, out_ready;
  logic [63:0] in_data, out_data;
  logic        in_ready, out_valid, busy;

  subs_layer_serial #(.BLOCK_SIZE(64), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inverse(in_inverse), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  logic             w_valid, w_inv, w_ready;
  logic [127:0]     w_data;
  logic [2:0]       wo_valid, wi_ready, wo_busy;
  logic [2:0][127:0] wo_data;

  subs_layer_serial #(.BLOCK_SIZE(128), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(wi_ready[0]),
    .in_data(w_data), .in_inverse(w_inv), .out_valid(wo_valid[0]),
    .out_ready(w_ready), .out_data(wo_data[0]), .busy(wo_busy[0])
  );
  subs_layer_serial #(.BLOCK_SIZE(128), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(wi_ready[1]),
    .in_data(w_data), .in_inverse(w_inv), .out_valid(wo_valid[1]),
    .out_ready(w_ready), .out_data(wo_data[1]), .busy(wo_busy[1])
  );
  subs_layer_serial #(.BLOCK_SIZE(128), .LANES(32)) u_l32 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(wi_ready[2]),
    .in_data(w_data), .in_inverse(w_inv), .out_valid(wo_valid[2]),
    .out_ready(w_ready), .out_data(wo_data[2]), .busy(wo_busy[2])
  );

  localparam logic [3:0] FWD_T [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] INV_T [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic        inv;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [127:0] sub_ref(input logic [127:0] d, input int nibbles,
                                           input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nibbles; i++)
      r[4*i +: 4] = inv ? INV_T[d[4*i +: 4]] : FWD_T[d[4*i +: 4]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one block, scribble on the inputs while it is in flight, stall, then pop it.
  task automatic run_block(input logic [63:0] d, input logic inv, input int stall,
                           output logic [63:0] res, output int lat);
    int  w;
    bit  busy_ok;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    in_data = d; in_inverse = inv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      in_data = {$urandom, $urandom};
      in_inverse = 1'($urandom);
      in_valid = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("busy_in_flight", 128'(busy_ok), 128'(1));
    repeat (stall) tick();
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t        vecs[6];
  logic [63:0] res;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; out_ready = 1'b0; in_data = '0;
    w_valid = 1'b0; w_inv = 1'b0; w_ready = 1'b0; w_data = '0;

    vecs[0] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC};
    vecs[1] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
    vecs[2] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
    vecs[4] = '{64'h0000000000000000, 1'b1, 64'h5555555555555555};
    vecs[5] = '{64'hCCCCCCCCCCCCCCCC, 1'b1, 64'h0000000000000000};

    tick(); tick();
    rst = 1'b0;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_out_data", 128'(out_data), 128'(0));

    // Vector table, alternating modes back to back.
    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].data, vecs[i].inv, i % 3, res, lat);
      check($sformatf("vec%0d_data", i), 128'(res), 128'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(4));
      check($sformatf("vec%0d_idle_after", i), 128'({in_ready, out_valid, busy}), 128'(3'b100));
    end

    // Backpressure: hold result for 10 cycles while in_valid pulses.
    in_data = 64'h0123456789ABCDEF; in_inverse = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("bp_latency", 128'(lat), 128'(4));
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom); in_data = {$urandom, $urandom}; in_inverse = 1'($urandom);
      tick();
      check("bp_data_stable", 128'(out_data), 128'(64'hC56B90AD3EF84712));
      check("bp_flags", 128'({in_ready, out_valid, busy}), 128'(3'b011));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // Reset after two of four groups.
    in_data = 64'h0123456789ABCDEF; in_inverse = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    check("midrst_out_data", 128'(out_data), 128'(0));
    run_block(64'h0, 1'b0, 0, res, lat);
    check("midrst_next_block", 128'(res), 128'(64'hCCCCCCCCCCCCCCCC));

    // Reset wins over in_valid.
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h5555;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("rst_vs_valid_flags", 128'({in_ready, busy}), 128'(2'b10));
    check("rst_vs_valid_data", 128'(out_data), 128'(0));

    // Throughput with out_ready tied high and in_valid held.
    begin
      int rises[$];
      logic prev;
      in_data = 64'h0123456789ABCDEF; in_inverse = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      prev = 1'b0;
      for (int c = 1; c <= 30 && rises.size() < 2; c++) begin
        tick();
        if (out_valid && !prev) begin
          rises.push_back(c);
          check("tput_data", 128'(out_data), 128'(64'hC56B90AD3EF84712));
          check("tput_no_overlap", 128'(in_ready), 128'(0));
        end
        prev = out_valid;
      end
      in_valid = 1'b0;
      check("tput_rise_count", 128'(rises.size()), 128'(2));
      if (rises.size() == 2) check("tput_period", 128'(rises[1] - rises[0]), 128'(6));
      lat = 0;
      while (busy && lat < 20) begin tick(); lat++; end
      out_ready = 1'b0;
      check("tput_drain", 128'(busy), 128'(0));
    end

    // Random blocks against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] d;
      logic        inv;
      d = {$urandom, $urandom};
      inv = 1'($urandom);
      run_block(d, inv, int'($urandom_range(0, 3)), res, lat);
      check("rand_data", 128'(res), sub_ref(128'(d), 16, inv));
      check("rand_latency", 128'(lat), 128'(4));
    end

    // 128-bit sweep across LANES = 1, 4, 32, both modes.
    for (int m = 0; m < 2; m++) begin
      int   lats[3];
      bit   seen[3];
      int   exp_lat[3];
      logic [127:0] exp_d;
      exp_lat = '{32, 8, 1};
      w_data = (m == 0) ? 128'h0123456789ABCDEF0123456789ABCDEF
                        : 128'hC56B90AD3EF84712C56B90AD3EF84712;
      exp_d  = (m == 0) ? 128'hC56B90AD3EF84712C56B90AD3EF84712
                        : 128'h0123456789ABCDEF0123456789ABCDEF;
      w_inv = 1'(m);
      w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin lats[i] = 0; seen[i] = 1'b0; end
      for (int c = 1; c <= 40; c++) begin
        tick();
        for (int i = 0; i < 3; i++)
          if (!seen[i] && wo_valid[i]) begin seen[i] = 1'b1; lats[i] = c; end
      end
      for (int i = 0; i < 3; i++) begin
        check($sformatf("sweep%0d_m%0d_latency", i, m), 128'(lats[i]), 128'(exp_lat[i]));
        check($sformatf("sweep%0d_m%0d_data", i, m), wo_data[i], exp_d);
        check($sformatf("sweep%0d_m%0d_model", i, m), wo_data[i], sub_ref(w_data, 32, w_inv));
      end
      w_ready = 1'b1;
      tick();
      w_ready = 1'b0;
      check($sformatf("sweep_m%0d_idle", m), 128'({wi_ready, wo_valid}), 128'(6'b111000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
